// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: data memory access with configurable
// latency, pipeline stall generation, MEM/WB register and branch resolution.
module mem_stage #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result_in,
  input  logic        zero_in,
  input  logic [31:0] read_d2_in,
  input  logic [4:0]  write_register_in,
  input  logic [2:0]  MEM_in,
  input  logic [1:0]  WB_in,
  output logic        pc_src,
  output logic        stall,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  write_register_out,
  output logic [1:0]  WB_out,
  output logic        misaligned
);

  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       mem [DEPTH];

  logic              mem_read, mem_write, mem_op;
  logic [ADDR_W-1:0] addr;
  logic              commit, bubble, issue, write_en;

  // A write takes precedence: both bits set means store only.
  assign mem_write = MEM_in[0];
  assign mem_read  = MEM_in[1] & ~MEM_in[0];
  assign mem_op    = MEM_in[1] | MEM_in[0];
  assign addr      = result_in[ADDR_W+1:2];
  assign pc_src    = MEM_in[2] & zero_in;
  assign issue     = (state_q == StIdle) & mem_op;
  assign write_en  = commit & mem_write & ~rst;

  // Next-state, counter, stall and MEM/WB load control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    commit  = 1'b0;
    bubble  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_op && (LATENCY != 0)) begin
          stall   = 1'b1;
          bubble  = 1'b1;
          cnt_d   = CntLoad;
          state_d = StBusy;
        end else begin
          commit = 1'b1;
        end
      end
      StBusy: begin
        // Completion cycle keeps stall low so upstream advances at this edge.
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = StIdle;
        end else begin
          stall  = 1'b1;
          bubble = 1'b1;
          cnt_d  = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and latency counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Data memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[addr] <= read_d2_in;
    end
  end

  // MEM/WB pipeline register and sticky misalignment flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data_out      <= '0;
      alu_result_out     <= '0;
      write_register_out <= '0;
      WB_out             <= '0;
      misaligned         <= 1'b0;
    end else begin
      if (commit) begin
        read_data_out      <= mem_read ? mem[addr] : 32'h0;
        alu_result_out     <= result_in;
        write_register_out <= write_register_in;
        WB_out             <= WB_in;
      end else if (bubble) begin
        read_data_out      <= '0;
        alu_result_out     <= '0;
        write_register_out <= '0;
        WB_out             <= '0;
      end
      if (issue && (result_in[1:0] != 2'b00)) begin
        misaligned <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] result_in = '0, read_d2_in = '0;
  logic        zero_in = 1'b0;
  logic [4:0]  write_register_in = '0;
  logic [2:0]  MEM_in = '0;
  logic [1:0]  WB_in = '0;
  logic        pc_src, stall, misaligned;
  logic [31:0] read_data_out, alu_result_out;
  logic [4:0]  write_register_out;
  logic [1:0]  WB_out;

  logic [31:0] z_result = '0, z_d2 = '0;
  logic [4:0]  z_wr = '0;
  logic [2:0]  z_mem = '0;
  logic [1:0]  z_wb = '0;
  logic        z_pc_src, z_stall, z_misaligned;
  logic [31:0] z_rdata, z_alu;
  logic [4:0]  z_wr_out;
  logic [1:0]  z_wb_out;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_stage #(.DEPTH(256), .ADDR_W(8), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .result_in(result_in), .zero_in(zero_in),
    .read_d2_in(read_d2_in), .write_register_in(write_register_in), .MEM_in(MEM_in),
    .WB_in(WB_in), .pc_src(pc_src), .stall(stall), .read_data_out(read_data_out),
    .alu_result_out(alu_result_out), .write_register_out(write_register_out),
    .WB_out(WB_out), .misaligned(misaligned)
  );

  mem_stage #(.DEPTH(256), .ADDR_W(8), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .result_in(z_result), .zero_in(1'b0),
    .read_d2_in(z_d2), .write_register_in(z_wr), .MEM_in(z_mem),
    .WB_in(z_wb), .pc_src(z_pc_src), .stall(z_stall), .read_data_out(z_rdata),
    .alu_result_out(z_alu), .write_register_out(z_wr_out),
    .WB_out(z_wb_out), .misaligned(z_misaligned)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] mem, input logic [31:0] res, input logic [31:0] d2,
                       input logic [4:0] wr, input logic [1:0] wb);
    MEM_in = mem; result_in = res; read_d2_in = d2; write_register_in = wr; WB_in = wb;
  endtask

  task automatic test_reset();
    drive(3'b000, 32'h0000_0777, 32'h0, 5'd3, 2'b10);
    step();
    rst = 1'b1;
    #1;
    vectors++;
    if ({read_data_out, alu_result_out, write_register_out, WB_out, misaligned, stall} !== '0) begin
      $display("FAIL reset_clear: got alu=%h wr=%0d wb=%b stall=%b exp all 0",
               alu_result_out, write_register_out, WB_out, stall);
      miscompares++;
    end
    rst = 1'b0;
    drive(3'b000, 32'h0000_1234, 32'h0, 5'd5, 2'b10);
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      $display("FAIL alu_no_stall: got %b exp 0", stall); miscompares++;
    end
    step();
    vectors++;
    if (alu_result_out !== 32'h1234 || write_register_out !== 5'd5 || WB_out !== 2'b10 ||
        read_data_out !== 32'h0) begin
      $display("FAIL alu_pass: got alu=%h wr=%0d wb=%b rd=%h exp 1234/5/10/0",
               alu_result_out, write_register_out, WB_out, read_data_out);
      miscompares++;
    end
  endtask

  task automatic test_store_load();
    drive(3'b001, 32'h10, 32'hDEAD_BEEF, 5'd0, 2'b00);
    #1;
    vectors++;
    if (stall !== 1'b1) begin $display("FAIL sw_stall0: got %b exp 1", stall); miscompares++; end
    step();
    vectors++;
    if (stall !== 1'b1 || WB_out !== 2'b00) begin
      $display("FAIL sw_stall1: got stall=%b wb=%b exp 1/00", stall, WB_out); miscompares++;
    end
    step();
    vectors++;
    if (stall !== 1'b0) begin $display("FAIL sw_stall_drop: got %b exp 0", stall); miscompares++; end
    step();
    // Back-to-back: load presented straight after store completion.
    drive(3'b010, 32'h10, 32'h0, 5'd8, 2'b11);
    #1;
    vectors++;
    if (stall !== 1'b1) begin $display("FAIL lw_b2b_stall: got %b exp 1", stall); miscompares++; end
    step();
    vectors++;
    if (WB_out !== 2'b00 || read_data_out !== 32'h0 || alu_result_out !== 32'h0) begin
      $display("FAIL lw_bubble: got wb=%b rd=%h alu=%h exp 00/0/0", WB_out, read_data_out,
               alu_result_out);
      miscompares++;
    end
    step();
    vectors++;
    if (stall !== 1'b0) begin $display("FAIL lw_stall_drop: got %b exp 0", stall); miscompares++; end
    step();
    vectors++;
    if (read_data_out !== 32'hDEAD_BEEF || WB_out !== 2'b11 || write_register_out !== 5'd8 ||
        alu_result_out !== 32'h10) begin
      $display("FAIL lw_result: got rd=%h wb=%b wr=%0d alu=%h exp deadbeef/11/8/10",
               read_data_out, WB_out, write_register_out, alu_result_out);
      miscompares++;
    end
    drive(3'b000, 32'h0, 32'h0, 5'd0, 2'b00);
    step();
  endtask

  task automatic test_latency0();
    z_mem = 3'b001; z_result = 32'h4; z_d2 = 32'hA5A5_A5A5; z_wr = 5'd0; z_wb = 2'b00;
    #1;
    vectors++;
    if (z_stall !== 1'b0) begin $display("FAIL l0_sw_stall: got %b exp 0", z_stall); miscompares++; end
    step();
    z_mem = 3'b010; z_d2 = 32'h0; z_wr = 5'd9; z_wb = 2'b11;
    #1;
    vectors++;
    if (z_stall !== 1'b0) begin $display("FAIL l0_lw_stall: got %b exp 0", z_stall); miscompares++; end
    step();
    vectors++;
    if (z_rdata !== 32'hA5A5_A5A5 || z_wb_out !== 2'b11 || z_wr_out !== 5'd9) begin
      $display("FAIL l0_lw_result: got rd=%h wb=%b wr=%0d exp a5a5a5a5/11/9", z_rdata, z_wb_out,
               z_wr_out);
      miscompares++;
    end
    z_mem = 3'b000;
    step();
  endtask

  task automatic test_wrap_misalign();
    drive(3'b001, 32'h400, 32'h1122_3344, 5'd0, 2'b00);
    step(); step(); step();
    vectors++;
    if (misaligned !== 1'b0) begin
      $display("FAIL aligned_no_flag: got %b exp 0", misaligned); miscompares++;
    end
    drive(3'b010, 32'h000, 32'h0, 5'd2, 2'b11);
    step(); step(); step();
    vectors++;
    if (read_data_out !== 32'h1122_3344) begin
      $display("FAIL wrap_read: got %h exp 11223344", read_data_out); miscompares++;
    end
    drive(3'b010, 32'h13, 32'h0, 5'd2, 2'b11);
    step();
    vectors++;
    if (misaligned !== 1'b1) begin
      $display("FAIL misalign_set: got %b exp 1", misaligned); miscompares++;
    end
    step(); step();
    drive(3'b000, 32'h0, 32'h0, 5'd0, 2'b00);
    step(); step();
    vectors++;
    if (misaligned !== 1'b1) begin
      $display("FAIL misalign_sticky: got %b exp 1", misaligned); miscompares++;
    end
  endtask

  task automatic test_branch();
    drive(3'b100, 32'h0, 32'h0, 5'd0, 2'b00);
    zero_in = 1'b1;
    #1;
    vectors++;
    if (pc_src !== 1'b1 || stall !== 1'b0) begin
      $display("FAIL br_taken: got pc_src=%b stall=%b exp 1/0", pc_src, stall); miscompares++;
    end
    zero_in = 1'b0;
    #1;
    vectors++;
    if (pc_src !== 1'b0 || stall !== 1'b0) begin
      $display("FAIL br_not_taken: got pc_src=%b stall=%b exp 0/0", pc_src, stall); miscompares++;
    end
    // Branch bit alongside a load: pc_src unaffected by the stall.
    MEM_in = 3'b110;
    zero_in = 1'b1;
    #1;
    vectors++;
    if (pc_src !== 1'b1 || stall !== 1'b1) begin
      $display("FAIL br_with_stall: got pc_src=%b stall=%b exp 1/1", pc_src, stall); miscompares++;
    end
    step(); step(); step();
    zero_in = 1'b0;
    drive(3'b000, 32'h0, 32'h0, 5'd0, 2'b00);
    step();
  endtask

  task automatic test_abort();
    drive(3'b001, 32'h20, 32'hCAFE_F00D, 5'd0, 2'b00);
    step(); step(); step();
    drive(3'b001, 32'h20, 32'hBADB_AD00, 5'd0, 2'b00);
    step();
    drive(3'b000, 32'h0, 32'h0, 5'd0, 2'b00);
    rst = 1'b1;
    #1;
    vectors++;
    if (stall !== 1'b0 || misaligned !== 1'b0 || WB_out !== 2'b00) begin
      $display("FAIL abort_reset: got stall=%b mis=%b wb=%b exp 0/0/00", stall, misaligned, WB_out);
      miscompares++;
    end
    step();
    rst = 1'b0;
    #1;
    vectors++;
    if (stall !== 1'b0) begin $display("FAIL abort_after: got %b exp 0", stall); miscompares++; end
    drive(3'b010, 32'h20, 32'h0, 5'd4, 2'b11);
    step(); step(); step();
    vectors++;
    if (read_data_out !== 32'hCAFE_F00D) begin
      $display("FAIL abort_no_write: got %h exp cafef00d", read_data_out); miscompares++;
    end
    drive(3'b000, 32'h0, 32'h0, 5'd0, 2'b00);
    step();
  endtask

  initial begin
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    test_reset();
    test_store_load();
    test_latency0();
    test_wrap_misalign();
    test_branch();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
